// File: rtl/iroot_if.sv
// Start/busy/done slave bus for the iroot integer root engine.
// The master drives the request fields and the slave drives the status and result fields.
interface iroot_if #(
   parameter int unsigned W = 16
);
   localparam int unsigned RW = (W + 1) / 2;

   logic          start;
   logic          mode;
   logic [W-1:0]  x_i;
   logic          busy;
   logic          done;
   logic [RW-1:0] result;
   logic [W-1:0]  rem;

   modport master (
      output start, mode, x_i,
      input  busy, done, result, rem
   );

   modport slave (
      input  start, mode, x_i,
      output busy, done, result, rem
   );
endinterface

// File: rtl/iroot.sv
// Multicycle floor cube/square root with remainder (restoring digit recurrence, shift-add multiplier).
// Define IROOT_SQRT_EN to build square-root mode; otherwise mode is ignored and only cube root exists.
module iroot #(
   parameter int unsigned W = 16
) (
   input  logic  clk,
   input  logic  rst_n,
   iroot_if.slave bus
);
   localparam int unsigned NC   = (W + 2) / 3;
   localparam int unsigned NS   = (W + 1) / 2;
   localparam int unsigned RW   = NS;
   localparam int unsigned PW   = 2 * RW;
   localparam int unsigned CW   = 2 * RW + 2;
   localparam int unsigned CNTW = $clog2(NS + 1);
   localparam int unsigned SW   = $clog2(W + 1);
   localparam int unsigned BCW  = $clog2(RW + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_MUL,
      S_TEST,
      S_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    xr, xr_d;
   logic            m, m_d;
   logic [RW-1:0]   y, y_d;
   logic [RW-1:0]   yd, yd_d;
   logic [CNTW-1:0] cnt, cnt_d;
   logic [SW-1:0]   s, s_d;
   logic [PW-1:0]   mcand, mcand_d;
   logic [RW-1:0]   mplier, mplier_d;
   logic [PW-1:0]   p, p_d;
   logic [BCW-1:0]  bc, bc_d;
   logic            busy_d, done_d;
   logic [RW-1:0]   result_d;
   logic [W-1:0]    rem_d;

   logic [CW-1:0]   xr_sh;
   logic [CW-1:0]   b_cube;
   logic [CW-1:0]   b;
   logic            fits;
   logic [W-1:0]    xr_sub;

   // Trial subtrahend: cube (y+1)^3-y^3 = 3p+1, square (y+1)^2-y^2 = 2yd+1
   assign xr_sh  = CW'(xr) >> s;
   assign b_cube = CW'(p) + (CW'(p) << 1) + CW'(1);
`ifdef IROOT_SQRT_EN
   logic [CW-1:0]   b_sq;
   assign b_sq = CW'({yd, 1'b1});
   assign b    = m ? b_sq : b_cube;
`else
   assign b    = b_cube;
`endif
   assign fits   = (xr_sh >= b);
   assign xr_sub = W'(CW'(xr) - (b << s));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         xr         <= '0;
         m          <= 1'b0;
         y          <= '0;
         yd         <= '0;
         cnt        <= '0;
         s          <= '0;
         mcand      <= '0;
         mplier     <= '0;
         p          <= '0;
         bc         <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.result <= '0;
         bus.rem    <= '0;
      end else begin
         state      <= state_nxt;
         xr         <= xr_d;
         m          <= m_d;
         y          <= y_d;
         yd         <= yd_d;
         cnt        <= cnt_d;
         s          <= s_d;
         mcand      <= mcand_d;
         mplier     <= mplier_d;
         p          <= p_d;
         bc         <= bc_d;
         bus.busy   <= busy_d;
         bus.done   <= done_d;
         bus.result <= result_d;
         bus.rem    <= rem_d;
      end
   end

   always_comb begin
      state_nxt = state;
      xr_d      = xr;
      m_d       = m;
      y_d       = y;
      yd_d      = yd;
      cnt_d     = cnt;
      s_d       = s;
      mcand_d   = mcand;
      mplier_d  = mplier;
      p_d       = p;
      bc_d      = bc;
      result_d  = bus.result;
      rem_d     = bus.rem;

      case (state)
         S_IDLE: begin
            if (bus.start) begin
               xr_d = bus.x_i;
`ifdef IROOT_SQRT_EN
               m_d  = bus.mode;
`else
               m_d  = 1'b0;
`endif
               y_d   = '0;
               cnt_d = m_d ? CNTW'(NS - 1) : CNTW'(NC - 1);
               s_d   = m_d ? SW'(2 * (NS - 1)) : SW'(3 * (NC - 1));
               state_nxt = S_PREP;
            end
         end
         S_PREP: begin
            yd_d = {y[RW-2:0], 1'b0};
            if (!m) begin
               mcand_d   = PW'(yd_d);
               mplier_d  = yd_d + RW'(1);
               p_d       = '0;
               bc_d      = '0;
               state_nxt = S_MUL;
            end else begin
               state_nxt = S_TEST;
            end
         end
         // One multiplier bit per cycle, exactly RW cycles
         S_MUL: begin
            if (mplier[0]) begin
               p_d = p + mcand;
            end
            mcand_d  = mcand << 1;
            mplier_d = mplier >> 1;
            if (bc == BCW'(RW - 1)) begin
               state_nxt = S_TEST;
            end else begin
               bc_d = bc + BCW'(1);
            end
         end
         S_TEST: begin
            if (fits) begin
               xr_d = xr_sub;
               y_d  = yd + RW'(1);
            end else begin
               y_d  = yd;
            end
            if (cnt == '0) begin
`ifdef IROOT_SQRT_EN
               result_d = y_d;
`else
               result_d = RW'(y_d[NC-1:0]);
`endif
               rem_d     = xr_d;
               state_nxt = S_DONE;
            end else begin
               cnt_d     = cnt - CNTW'(1);
               s_d       = m ? (s - SW'(2)) : (s - SW'(3));
               state_nxt = S_PREP;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      busy_d = (state_nxt != S_IDLE);
      done_d = (state_nxt == S_DONE);
   end
endmodule

// File: tb/tb_iroot.sv
// Directed-vector bench for iroot (W=16 and W=24 instances); honours IROOT_SQRT_EN.
module tb_iroot;
`ifdef IROOT_SQRT_EN
   localparam bit SQ = 1'b1;
`else
   localparam bit SQ = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   iroot_if #(.W(16)) b16 ();
   iroot_if #(.W(24)) b24 ();

   iroot #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
   iroot #(.W(24)) dut24 (.clk(clk), .rst_n(rst_n), .bus(b24));

   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic [15:0] x;
      logic [7:0]  res;
      logic [15:0] rem;
      int          lat;
   } vec_t;

   vec_t tv[18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int unsigned mroot(input logic md, input int unsigned x);
      int unsigned r = 0;
      if (md) begin
         while ((r + 1) * (r + 1) <= x) r++;
      end else begin
         while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
      end
      return r;
   endfunction

   // Issue one request on the W=16 bus; returns in the DONE cycle (or after the time-out)
   task automatic run16(input logic md, input logic [15:0] x,
                        output logic [7:0] r, output logic [15:0] rm, output int lat);
      @(negedge clk);
      b16.start = 1'b1;
      b16.mode  = md;
      b16.x_i   = x;
      @(negedge clk);
      b16.start = 1'b0;
      lat = -1;
      for (int c = 1; c <= 200; c++) begin
         if (b16.done) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      r  = b16.result;
      rm = b16.rem;
   endtask

   initial begin
      logic [7:0]  r;
      logic [15:0] rm;
      int          lat;
      int          ndone;
      int unsigned ex;
      int unsigned er;
      logic        md;
      logic        eff;
      logic [15:0] xs;

      checks = 0;
      errors = 0;
      clk    = 1'b0;
      rst_n  = 1'b0;
      b16.start = 1'b0; b16.mode = 1'b0; b16.x_i = '0;
      b24.start = 1'b0; b24.mode = 1'b0; b24.x_i = '0;

      tv[0]  = '{1'b0, 16'd27,    8'd3,  16'd0,    61};
      tv[1]  = '{1'b0, 16'd65535, 8'd40, 16'd1535, 61};
      tv[2]  = '{1'b0, 16'd0,     8'd0,  16'd0,    61};
      tv[3]  = '{1'b0, 16'd1,     8'd1,  16'd0,    61};
      tv[4]  = '{1'b0, 16'd7,     8'd1,  16'd6,    61};
      tv[5]  = '{1'b0, 16'd8,     8'd2,  16'd0,    61};
      tv[6]  = '{1'b0, 16'd63,    8'd3,  16'd36,   61};
      tv[7]  = '{1'b0, 16'd1000,  8'd10, 16'd0,    61};
      tv[8]  = '{1'b0, 16'd999,   8'd9,  16'd270,  61};
      tv[9]  = '{1'b0, 16'd63999, 8'd39, 16'd4680, 61};
      tv[10] = '{1'b0, 16'd64000, 8'd40, 16'd0,    61};
`ifdef IROOT_SQRT_EN
      tv[11] = '{1'b1, 16'd65535, 8'd255, 16'd510, 17};
      tv[12] = '{1'b1, 16'd0,     8'd0,   16'd0,   17};
      tv[13] = '{1'b1, 16'd1,     8'd1,   16'd0,   17};
      tv[14] = '{1'b1, 16'd15,    8'd3,   16'd6,   17};
      tv[15] = '{1'b1, 16'd16,    8'd4,   16'd0,   17};
      tv[16] = '{1'b1, 16'd65025, 8'd255, 16'd0,   17};
      tv[17] = '{1'b1, 16'd65024, 8'd254, 16'd508, 17};
`else
      tv[11] = '{1'b1, 16'd65535, 8'd40, 16'd1535, 61};
      tv[12] = '{1'b1, 16'd0,     8'd0,  16'd0,    61};
      tv[13] = '{1'b1, 16'd1,     8'd1,  16'd0,    61};
      tv[14] = '{1'b1, 16'd15,    8'd2,  16'd7,    61};
      tv[15] = '{1'b1, 16'd16,    8'd2,  16'd8,    61};
      tv[16] = '{1'b1, 16'd65025, 8'd40, 16'd1025, 61};
      tv[17] = '{1'b1, 16'd65024, 8'd40, 16'd1024, 61};
`endif

      #12;
      chk("reset_busy",   64'(b16.busy),   64'd0);
      chk("reset_done",   64'(b16.done),   64'd0);
      chk("reset_result", 64'(b16.result), 64'd0);
      chk("reset_rem",    64'(b16.rem),    64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         run16(tv[i].mode, tv[i].x, r, rm, lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tv[i].lat));
         chk($sformatf("vec%0d_result", i),  64'(r),   64'(tv[i].res));
         chk($sformatf("vec%0d_rem", i),     64'(rm),  64'(tv[i].rem));
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), 64'(b16.done), 64'd0);
         chk($sformatf("vec%0d_busy_fall", i),  64'(b16.busy), 64'd0);
      end

      // Sparse sweep against a plain reference root
      for (int i = 0; i < 100; i++) begin
         xs  = 16'(i * 661 + (i % 7));
         md  = 1'(i % 2);
         eff = md & SQ;
         ex  = mroot(eff, 32'(xs));
         er  = eff ? (32'(xs) - ex * ex) : (32'(xs) - ex * ex * ex);
         run16(md, xs, r, rm, lat);
         chk($sformatf("sweep_x%0d_result", xs), 64'(r),  64'(ex));
         chk($sformatf("sweep_x%0d_rem", xs),    64'(rm), 64'(er));
      end

      // W=24 full-scale cube
      @(negedge clk);
      b24.start = 1'b1; b24.mode = 1'b0; b24.x_i = 24'd16777215;
      @(negedge clk);
      b24.start = 1'b0;
      chk("w24_busy_rise", 64'(b24.busy), 64'd1);
      lat = -1;
      for (int c = 1; c <= 300; c++) begin
         if (b24.done) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      chk("w24_latency", 64'(lat),        64'd113);
      chk("w24_result",  64'(b24.result), 64'd255);
      chk("w24_rem",     64'(b24.rem),    64'd195840);

      // Start while busy is dropped; start held in the DONE cycle is dropped too
      @(negedge clk);
      b16.start = 1'b1; b16.mode = 1'b0; b16.x_i = 16'd64;
      @(negedge clk);
      b16.start = 1'b0;
      repeat (5) @(negedge clk);
      b16.start = 1'b1; b16.x_i = 16'd1000;
      @(negedge clk);
      b16.start = 1'b0;
      ndone = 0;
      lat   = -1;
      for (int c = 7; c <= 150; c++) begin
         if (b16.done) begin
            ndone++;
            if (lat < 0) begin
               lat = c;
               chk("busy_start_result", 64'(b16.result), 64'd4);
               chk("busy_start_rem",    64'(b16.rem),    64'd0);
               b16.start = 1'b1; b16.x_i = 16'd125;
            end
         end else begin
            b16.start = 1'b0;
         end
         @(negedge clk);
      end
      chk("busy_start_latency",   64'(lat),      64'd61);
      chk("busy_start_done_cnt",  64'(ndone),    64'd1);
      chk("done_cycle_start_idle", 64'(b16.busy), 64'd0);

      // Asynchronous reset at cycle 20 of a cube run
      @(negedge clk);
      b16.start = 1'b1; b16.mode = 1'b0; b16.x_i = 16'd65535;
      @(negedge clk);
      b16.start = 1'b0;
      repeat (19) @(negedge clk);
      chk("pre_reset_busy", 64'(b16.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy",   64'(b16.busy),   64'd0);
      chk("abort_result", 64'(b16.result), 64'd0);
      chk("abort_rem",    64'(b16.rem),    64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 80; c++) begin
         if (b16.done || b16.busy) ndone++;
         @(negedge clk);
      end
      chk("abort_no_activity", 64'(ndone), 64'd0);
      run16(1'b0, 16'd125, r, rm, lat);
      chk("post_reset_latency", 64'(lat), 64'd61);
      chk("post_reset_result",  64'(r),   64'd5);
      chk("post_reset_rem",     64'(rm),  64'd0);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/iroot.md
# iroot

Parametrised integer root engine: a multicycle successor to the fixed 16-bit cube-root unit. It computes floor(cbrt(x)) or floor(sqrt(x)) of a W-bit unsigned operand, plus the remainder, using a restoring digit-by-digit method and one internal shift-add multiplier. It sits beside the existing arithmetic blocks as a start/busy/done slave on a single clock domain.

## Interface
- W, 16, operand width in bits; legal range 4..32.
- NC, ceil(W/3), derived: cube-root result bits and cube iterations.
- NS, ceil(W/2), derived: square-root result bits and square iterations.
- RW, NS, derived: width of the result port.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = cube root, 1 = square root; sampled together with start.
- x_i  in  W  unsigned operand; sampled together with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the DONE state.
- result  out  RW  root; cube results are zero-extended from NC bits.
- rem  out  W  x_i minus result^k, where k is 3 or 2.

## Operation
- States: IDLE, PREP, MUL, TEST, DONE.
- IDLE with start=1: latch x_i into working register xr and mode into m.
  - Clear y and set the iteration counter to N-1, with N = NC (cube) or NS (square).
  - Set shift s = 3(N-1) or 2(N-1). Go to PREP.
- PREP: set yd = 2y.
  - Cube: load the multiplier with yd and yd+1, then go to MUL.
  - Square: go directly to TEST.
- MUL: the shift-add multiplier processes one bit of the RW-bit multiplier operand per cycle. Stay for exactly RW cycles, then go to TEST. The product p is 2RW bits.
- TEST: compute b.
  - Cube: b = 3p+1, width 2RW+2.
  - Square: b = 2yd+1, width RW+1.
  - If (xr >> s) >= b: xr <= xr - (b << s) and y <= yd+1. Otherwise y <= yd.
  - The comparison is made on xr >> s, so b << s never overflows W bits.
  - If the counter is 0: go to DONE. Otherwise decrement the counter, decrease s by 3 (cube) or 2 (square), and go to PREP.
- DONE: result <= y and rem <= xr. done=1 for this cycle only, then go to IDLE.
- start while busy is ignored; it is not queued.
- x_i = 0 follows the full iteration sequence and gives result=0, rem=0.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, result=0, rem=0.
  - All internal registers (xr, y, yd, counter, s, multiplier state) are 0.
- Reset asserted mid-operation aborts at once and no done pulse is produced. After release the block waits in IDLE for a new start.
- start is accepted at edge E0, and busy rises after E0.
- Cube iteration = RW+2 cycles; square iteration = 2 cycles.
- done is high during cycle N·(iteration) + 1 after E0.
  - W=16 cube: cycle 61 (NC=6, RW=8).
  - W=16 square: cycle 17.
- result and rem update on the edge that enters DONE. They hold until the next DONE or reset.
- busy falls on the edge leaving DONE. A start applied in the cycle where done=1 is ignored. The earliest accepted start is in the following IDLE cycle.

## Configuration
- IROOT_SQRT_EN defined: square-root mode is built and mode selects the operation as above.
- IROOT_SQRT_EN undefined:
  - The mode port remains but is ignored and treated as 0.
  - Only cube root is computed and the square-root b-path is not synthesised.
  - Result bits above NC are always 0.

## Test plan
- W=16, mode=0, x_i=27 -> done at cycle 61, result=3, rem=0; x_i=65535 -> result=40, rem=1535.
- W=16, IROOT_SQRT_EN defined, mode=1, x_i=65535 -> done at cycle 17, result=255, rem=510. The same case without the macro -> result=40, rem=1535.
- W=24, mode=0, x_i=16777215 -> result=255, rem=195840, done at cycle 8·14+1=113.
- W=16, x_i=0 in both modes -> result=0, rem=0. Sweep x_i over 0..65535 against a reference model: result^k <= x_i < (result+1)^k and rem = x_i - result^k.
- Pulse start with x_i=1000 while busy on a run started with x_i=64 -> the second start is ignored; the output is result=4, rem=0 with exactly one done pulse.
- Drive rst_n low at cycle 20 of a cube run -> busy=0, result=0, rem=0 immediately and no done pulse. A fresh start with x_i=125 then gives result=5.
